// File: rtl/tl_mem_responder.sv
// tl_mem_responder
// TileLink-UL memory responder sitting at the far end of an A/D memory port.
// Single-beat Get / PutFullData / PutPartialData are served from an internal
// single-ported word array. Every accepted request produces exactly one D
// response, delivered in acceptance order after a fixed LATENCY.
//
// Ports
//   clk, rst            sole clock (rising edge), synchronous active-high reset
//   a_valid_i/a_ready_o request handshake
//   a_opcode_i          0=PutFullData, 1=PutPartialData, 4=Get
//   a_size_i            log2 bytes, echoed on d_size_o
//   a_source_i          tag, echoed on d_source_o
//   a_address_i         byte address
//   a_mask_i            byte enables for Puts
//   a_data_i            write data
//   a_param_i           ignored
//   d_valid_o/d_ready_i response handshake
//   d_opcode_o          0=AccessAck, 1=AccessAckData
//   d_size_o            echoed size
//   d_source_o          echoed source
//   d_data_o            read data, zero for AccessAck
//   d_param_o           always zero
//   err_o               sticky: unmapped address or unsupported opcode seen
module tl_mem_responder #(
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned DATA_BITS    = 64,
    parameter int unsigned SOURCE_BITS  = 8,
    parameter int unsigned SIZE_BITS    = 3,
    parameter int unsigned OP_BITS      = 3,
    parameter int unsigned MEM_WORDS    = 1024,
    parameter logic [ADDRESS_BITS-1:0] BASE_ADDR = '0,
    parameter int unsigned RSP_DEPTH    = 4,
    parameter int unsigned LATENCY      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid_i,
    output logic                     a_ready_o,
    input  logic [OP_BITS-1:0]       a_opcode_i,
    input  logic [SIZE_BITS-1:0]     a_size_i,
    input  logic [SOURCE_BITS-1:0]   a_source_i,
    input  logic [ADDRESS_BITS-1:0]  a_address_i,
    input  logic [DATA_BITS/8-1:0]   a_mask_i,
    input  logic [DATA_BITS-1:0]     a_data_i,
    input  logic [2:0]               a_param_i,
    output logic                     d_valid_o,
    input  logic                     d_ready_i,
    output logic [OP_BITS-1:0]       d_opcode_o,
    output logic [SIZE_BITS-1:0]     d_size_o,
    output logic [SOURCE_BITS-1:0]   d_source_o,
    output logic [DATA_BITS-1:0]     d_data_o,
    output logic [2:0]               d_param_o,
    output logic                     err_o
);

    localparam int unsigned STRB_BITS = DATA_BITS / 8;
    localparam int unsigned OFF_BITS  = $clog2(STRB_BITS);
    localparam int unsigned IDX_BITS  = $clog2(MEM_WORDS);
    localparam int unsigned PTR_BITS  = $clog2(RSP_DEPTH);
    localparam int unsigned OCC_BITS  = PTR_BITS + 1;
    localparam int unsigned CNT_BITS  = $clog2(LATENCY + 1);

    localparam logic [ADDRESS_BITS:0] MEM_BYTES =
        (ADDRESS_BITS+1)'(64'(MEM_WORDS) * 64'(STRB_BITS));
    localparam logic [CNT_BITS-1:0]   LAT_INIT  = CNT_BITS'(LATENCY - 1);
    localparam logic [OCC_BITS-1:0]   OCC_FULL  = OCC_BITS'(RSP_DEPTH);

    localparam logic [OP_BITS-1:0] OP_PUT_FULL = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_PUT_PART = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_GET      = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] D_ACK       = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] D_ACK_DATA  = OP_BITS'(1);

    // Storage: no reset, contents survive rst.
    logic [DATA_BITS-1:0]   mem_q [MEM_WORDS];

    // Response queue entries.
    logic [OP_BITS-1:0]     q_op_q   [RSP_DEPTH];
    logic [SIZE_BITS-1:0]   q_size_q [RSP_DEPTH];
    logic [SOURCE_BITS-1:0] q_src_q  [RSP_DEPTH];
    logic [DATA_BITS-1:0]   q_data_q [RSP_DEPTH];
    logic [CNT_BITS-1:0]    q_cnt_q  [RSP_DEPTH];

    logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_BITS-1:0]    occ_q, occ_d;
    logic                   err_q, err_d;

    // Address decode. The extra top bit of diff is the borrow, i.e. address
    // below BASE_ADDR, which also makes diff exceed MEM_BYTES.
    logic [ADDRESS_BITS:0]  diff;
    logic                   mapped;
    logic [IDX_BITS-1:0]    idx;
    logic                   is_put, is_get, bad_op;
    logic                   push, pop;
    logic [DATA_BITS-1:0]   rd_word;

    assign diff   = {1'b0, a_address_i} - {1'b0, BASE_ADDR};
    assign mapped = !diff[ADDRESS_BITS] && (diff < MEM_BYTES);
    assign idx    = diff[OFF_BITS +: IDX_BITS];

    assign is_put = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PART);
    assign is_get = (a_opcode_i == OP_GET);
    assign bad_op = !(is_put || is_get);

    // a_ready depends only on registered occupancy, never on d_ready_i.
    assign a_ready_o = !rst && (occ_q < OCC_FULL);
    assign d_valid_o = !rst && (occ_q != '0) && (q_cnt_q[rd_ptr_q] == '0);

    assign push = a_valid_i && a_ready_o;
    assign pop  = d_valid_o && d_ready_i;

    assign rd_word = (is_get && mapped) ? mem_q[idx] : '0;

    always_ff @(posedge clk) begin
        if (push && is_put && mapped) begin
            for (int b = 0; b < int'(STRB_BITS); b++) begin
                if (a_mask_i[b]) begin
                    mem_q[idx][8*b +: 8] <= a_data_i[8*b +: 8];
                end
            end
        end
    end

    // Countdowns run on every slot; only occupied slots are ever observed.
    // A push into a slot overrides its decrement.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(RSP_DEPTH); i++) begin
            if (q_cnt_q[i] != '0) begin
                q_cnt_q[i] <= q_cnt_q[i] - CNT_BITS'(1);
            end
        end
        if (push) begin
            q_op_q[wr_ptr_q]   <= is_get ? D_ACK_DATA : D_ACK;
            q_size_q[wr_ptr_q] <= a_size_i;
            q_src_q[wr_ptr_q]  <= a_source_i;
            q_data_q[wr_ptr_q] <= rd_word;
            q_cnt_q[wr_ptr_q]  <= LAT_INIT;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
            if (!mapped || bad_op) begin
                err_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_BITS'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OCC_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

    // D fields are forced to zero whenever no response is presented.
    assign d_opcode_o = d_valid_o ? q_op_q[rd_ptr_q]   : '0;
    assign d_size_o   = d_valid_o ? q_size_q[rd_ptr_q] : '0;
    assign d_source_o = d_valid_o ? q_src_q[rd_ptr_q]  : '0;
    assign d_data_o   = d_valid_o ? q_data_q[rd_ptr_q] : '0;
    assign d_param_o  = '0;
    assign err_o      = err_q;

endmodule

// File: tb/tb_tl_mem_responder.sv
module tb_tl_mem_responder;

    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_valid, a_ready, d_valid, d_ready, err;
    logic [2:0]  a_opcode, a_size, a_param, d_opcode, d_size, d_param;
    logic [7:0]  a_source, a_mask, d_source;
    logic [31:0] a_address;
    logic [63:0] a_data, d_data;

    logic        b_a_valid, b_a_ready, b_d_valid, b_d_ready, b_err;
    logic [2:0]  b_a_opcode, b_a_size, b_a_param, b_d_opcode, b_d_size, b_d_param;
    logic [7:0]  b_a_source, b_a_mask, b_d_source;
    logic [31:0] b_a_address;
    logic [63:0] b_a_data, b_d_data;

    tl_mem_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode),
        .a_size_i(a_size), .a_source_i(a_source), .a_address_i(a_address),
        .a_mask_i(a_mask), .a_data_i(a_data), .a_param_i(a_param),
        .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode),
        .d_size_o(d_size), .d_source_o(d_source), .d_data_o(d_data),
        .d_param_o(d_param), .err_o(err)
    );

    tl_mem_responder #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .a_valid_i(b_a_valid), .a_ready_o(b_a_ready), .a_opcode_i(b_a_opcode),
        .a_size_i(b_a_size), .a_source_i(b_a_source), .a_address_i(b_a_address),
        .a_mask_i(b_a_mask), .a_data_i(b_a_data), .a_param_i(b_a_param),
        .d_valid_o(b_d_valid), .d_ready_i(b_d_ready), .d_opcode_o(b_d_opcode),
        .d_size_o(b_d_size), .d_source_o(b_d_source), .d_data_o(b_d_data),
        .d_param_o(b_d_param), .err_o(b_err)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [7:0]  src;
        logic [63:0] data;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb2[$];
    logic [63:0] mdl [int];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          lat_chk = 0;
    bit          bp_en = 0;
    int          last_acc = 0;
    int          first_pop = -1;
    int          dv_cnt = 0;
    int          pops2 = 0;
    bit          head_seen = 0;
    bit          prev_hold = 0;
    logic [63:0] prev_data;
    logic [7:0]  prev_src;
    logic [63:0] last_data;
    logic [7:0]  last_src;
    logic [2:0]  last_op;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mdl_rd(input int idx);
        return mdl.exists(idx) ? mdl[idx] : 64'h0;
    endfunction

    // Drive one request (called at a negedge); returns at the negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [31:0] addr,
                        input logic [63:0] data, input logic [7:0] mask,
                        input logic [7:0] src);
        exp_t        e;
        int          idx;
        int          n;
        bit          mapped;
        logic [63:0] w;
        n = 0;
        a_valid = 1'b1; a_opcode = op; a_address = addr; a_data = data;
        a_mask = mask; a_source = src; a_size = 3'd3;
        while (!a_ready) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                chk("accept_timeout", 64'd0, 64'd1);
                a_valid = 1'b0;
                return;
            end
        end
        mapped = (addr < 32'h2000);
        idx    = int'(addr[12:3]);
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size = 3'd3;
        e.src  = src;
        e.acc  = cyc + 1;
        e.lat  = lat_chk;
        e.data = (op == 3'd4 && mapped) ? mdl_rd(idx) : 64'h0;
        if ((op == 3'd0 || op == 3'd1) && mapped) begin
            w = mdl_rd(idx);
            for (int b = 0; b < 8; b++) if (mask[b]) w[8*b +: 8] = data[8*b +: 8];
            mdl[idx] = w;
        end
        sb.push_back(e);
        last_acc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic idle();
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (bp_en) d_ready = 1'($urandom_range(0, 1));
    end

    // Response monitor for the LATENCY=3 instance, sampled mid low phase.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst) begin
            head_seen = 0;
            prev_hold = 0;
        end else begin
            if (d_valid) dv_cnt++;
            if (prev_hold) begin
                chk("hold_valid", 64'(d_valid), 64'd1);
                chk("hold_data", d_data, prev_data);
                chk("hold_src", 64'(d_source), 64'(prev_src));
            end
            if (d_valid && !head_seen) begin
                head_seen = 1;
                if (sb.size() > 0 && sb[0].lat) chk("latency", 64'(cyc + 1 - sb[0].acc), 64'(LAT));
            end
            if (d_valid && d_ready) begin
                if (first_pop < 0) first_pop = cyc + 1;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("d_opcode", 64'(d_opcode), 64'(e.op));
                    chk("d_source", 64'(d_source), 64'(e.src));
                    chk("d_data", d_data, e.data);
                    chk("d_size", 64'(d_size), 64'(e.size));
                    chk("d_param", 64'(d_param), 64'd0);
                end
                last_data = d_data;
                last_src  = d_source;
                last_op   = d_opcode;
                head_seen = 0;
            end
            prev_hold = d_valid && !d_ready;
            prev_data = d_data;
            prev_src  = d_source;
        end
    end

    // Response monitor for the LATENCY=1 instance.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && b_d_valid && b_d_ready) begin
            pops2++;
            if (sb2.size() == 0) begin
                chk("l1_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb2.pop_front();
                chk("l1_d_opcode", 64'(b_d_opcode), 64'(e.op));
                chk("l1_d_source", 64'(b_d_source), 64'(e.src));
                chk("l1_d_data", b_d_data, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1; d_ready = 1'b1;
        a_valid = 0; a_opcode = 0; a_size = 0; a_param = 0; a_source = 0;
        a_address = 0; a_mask = 0; a_data = 0;
        b_a_valid = 0; b_a_opcode = 0; b_a_size = 0; b_a_param = 0; b_a_source = 0;
        b_a_address = 0; b_a_mask = 0; b_a_data = 0; b_d_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_d_valid", 64'(d_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_d_data", d_data, 64'd0);
        chk("rst_d_opcode", 64'(d_opcode), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("a_ready_after_rst", 64'(a_ready), 64'd1);

        // Put then Get of the same word on consecutive cycles.
        lat_chk = 1;
        send(3'd0, 32'h10, 64'h1122334455667788, 8'hFF, 8'd5);
        send(3'd4, 32'h10, 64'h0, 8'h00, 8'd6);
        idle();
        drain();
        lat_chk = 0;
        chk("get_after_put", last_data, 64'h1122334455667788);
        chk("get_after_put_src", 64'(last_src), 64'd6);

        send(3'd1, 32'h10, 64'hAA, 8'h01, 8'd7);
        send(3'd4, 32'h10, 64'h0, 8'h00, 8'd8);
        idle();
        drain();
        chk("partial_put", last_data, 64'h11223344556677AA);
        chk("err_clean", 64'(err), 64'd0);

        // Randomised traffic on a few words with random back-pressure.
        for (int k = 0; k < 4; k++)
            send(3'd0, 32'h100 + 32'(8*k), {$urandom, $urandom}, 8'hFF, 8'(40 + k));
        bp_en = 1;
        for (int i = 0; i < 16; i++) begin
            int          sel;
            logic [31:0] ad;
            sel = $urandom_range(0, 2);
            ad  = 32'h100 + 32'(8 * $urandom_range(0, 3)) + 32'($urandom_range(0, 7));
            if (sel == 2) send(3'd4, ad, 64'h0, 8'h00, 8'(50 + i));
            else send(3'(sel), ad, {$urandom, $urandom}, 8'($urandom), 8'(50 + i));
        end
        idle();
        drain();
        bp_en = 0;
        @(negedge clk);

        // Fill the queue under back-pressure, then release it.
        d_ready = 1'b0;
        for (int s = 10; s < 14; s++) send(3'd4, 32'h100, 64'h0, 8'h00, 8'(s));
        idle();
        chk("full_a_ready", 64'(a_ready), 64'd0);
        repeat (4) @(negedge clk);
        chk("full_a_ready_hold", 64'(a_ready), 64'd0);
        first_pop = -1;
        d_ready = 1'b1;
        send(3'd4, 32'h100, 64'h0, 8'h00, 8'd14);
        idle();
        chk("fifth_accept_edge", 64'(last_acc), 64'(first_pop + 1));
        drain();
        chk("fifth_src_last", 64'(last_src), 64'd14);

        // Unmapped accesses.
        send(3'd0, 32'h8, 64'h0102030405060708, 8'hFF, 8'd19);
        send(3'd4, 32'h4000, 64'h0, 8'h00, 8'd20);
        idle();
        drain();
        chk("unmapped_get_data", last_data, 64'h0);
        chk("unmapped_get_op", 64'(last_op), 64'd1);
        chk("err_set", 64'(err), 64'd1);
        send(3'd0, 32'h4008, 64'hDEADBEEFDEADBEEF, 8'hFF, 8'd21);
        send(3'd4, 32'h8, 64'h0, 8'h00, 8'd22);
        idle();
        drain();
        chk("unmapped_put_dropped", last_data, 64'h0102030405060708);
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);

        // Reset with responses still queued.
        d_ready = 1'b0;
        for (int s = 23; s < 26; s++) send(3'd4, 32'h10, 64'h0, 8'h00, 8'(s));
        idle();
        repeat (4) @(negedge clk);
        chk("queued_d_valid", 64'(d_valid), 64'd1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_d_valid", 64'(d_valid), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        chk("midrst_a_ready", 64'(a_ready), 64'd0);
        chk("midrst_d_source", 64'(d_source), 64'd0);
        rst = 1'b0;
        d_ready = 1'b1;
        dv_cnt = 0;
        repeat (8) @(negedge clk);
        chk("no_stale_rsp", 64'(dv_cnt), 64'd0);
        send(3'd4, 32'h10, 64'h0, 8'h00, 8'd26);
        idle();
        drain();
        chk("mem_kept_over_rst", last_data, 64'h11223344556677AA);

        // Unsupported opcode.
        send(3'd2, 32'h10, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'd30);
        idle();
        drain();
        chk("bad_op_ack", 64'(last_op), 64'd0);
        chk("bad_op_err", 64'(err), 64'd1);
        send(3'd4, 32'h10, 64'h0, 8'h00, 8'd31);
        idle();
        drain();
        chk("bad_op_no_write", last_data, 64'h11223344556677AA);

        // LATENCY=1 instance: one accept and one response every cycle.
        b_d_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [63:0] wd;
            wd = 64'hA5A5_0000_0000_0000 | 64'(i % 10);
            b_a_valid = 1'b1;
            b_a_opcode = (i < 10) ? 3'd0 : 3'd4;
            b_a_address = 32'(8 * (i % 10));
            b_a_data = wd;
            b_a_mask = 8'hFF;
            b_a_source = 8'(i);
            b_a_size = 3'd3;
            chk("l1_a_ready", 64'(b_a_ready), 64'd1);
            if (i > 0) chk("l1_d_valid_sustained", 64'(b_d_valid), 64'd1);
            e.op = (i < 10) ? 3'd0 : 3'd1;
            e.size = 3'd3;
            e.src = 8'(i);
            e.data = (i < 10) ? 64'h0 : wd;
            e.acc = cyc + 1;
            e.lat = 0;
            sb2.push_back(e);
            @(negedge clk);
        end
        b_a_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("l1_pop_count", 64'(pops2), 64'd20);
        chk("l1_sb_empty", 64'(sb2.size()), 64'd0);
        chk("l1_err", 64'(b_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
